chaining_record_writer: RTL and testbench
=========================================

Name: chaining_record_writer

Overview:
- Writer-side owner of one chaining record: allocates on instruction issue, marks element groups of vd/vd+1 as written while the execution unit writes back, releases on retire.
- Drives the record fields consumed by the chaining read-hazard checkers: vd, instIndex, elementMask and recordValid.
- One instance per chaining slot in the sequencer's VRF write path.

Parameters:
- OFFSET_W, 8, element-group offset width per register (256 groups per register).
- REG_IDX_W, 3, register index bits within an 8-register mask window.
- MASK_W, 2048, elementMask width = 2^(REG_IDX_W+OFFSET_W); derived, do not override.
- CNT_W, 12, written-group counter width = log2(MASK_W)+1; derived.

Ports:
- clock in 1: single clock.
- reset in 1: synchronous, active-high.
- alloc_valid in 1: allocation request.
- alloc_ready out 1: record free (state IDLE).
- alloc_vd_valid in 1: instruction writes a vector vd.
- alloc_vd in 5: destination register.
- alloc_instIndex in 3: instruction index.
- alloc_groupCount in 12: element groups the instruction writes (1..2048).
- write_valid in 1: one VRF write completed; no backpressure.
- write_vs in 5: register written.
- write_offset in 8: element-group offset written.
- write_instIndex in 3: owner of the write.
- finish_valid in 1: retire/kill of instruction.
- finish_instIndex in 3: instance being retired.
- record_bits_vd_valid out 1: registered alloc_vd_valid.
- record_bits_vd_bits out 5: registered vd.
- record_bits_instIndex out 3: registered instIndex.
- record_bits_elementMask out 2048: bit {reg[2:0],offset} = 1 once that group is written.
- recordValid out 1: record active (ACTIVE or DONE).
- record_done out 1: all groups written (state DONE).

Behaviour:
- FSM states IDLE, ACTIVE, DONE. Reset: IDLE; all outputs 0, alloc_ready=1.
- IDLE → ACTIVE on alloc_valid (alloc_ready=1). Next cycle: fields loaded, elementMask=0, counter=0, recordValid=1.
- ACTIVE: write_valid with write_instIndex==record_bits_instIndex and vd_valid=1 sets bit {write_vs[2:0], write_offset} next cycle.
  - Counter increments only if that bit was previously 0; duplicate writes leave the counter unchanged.
  - Writes with a mismatched instIndex are ignored. Writes while IDLE or DONE are ignored.
  - Writes with write_vs[4:3] not equal to vd[4:3] or vd[4:3]+1 (mod 4) are ignored.
- ACTIVE → DONE when the counter after this cycle's update equals groupCount, including the same cycle as the last write.
- DONE: elementMask frozen, record_done=1, recordValid stays 1.
- ACTIVE/DONE → IDLE on finish_valid with finish_instIndex==record_bits_instIndex. Next cycle: recordValid=0, elementMask cleared, alloc_ready=1.
- Kill mid-ACTIVE is allowed and follows the same path.
- Write and matching finish in the same cycle: the finish wins; the result is IDLE with the mask cleared.
- finish and alloc in the same cycle while IDLE: alloc taken; the finish is ignored because no record matches.
- alloc_vd_valid=0: record held only for ordering. recordValid=1, mask never updated, no transition to DONE; IDLE only via finish.
- Latency: every effect is visible exactly one cycle after the input. No combinational path from inputs to outputs except alloc_ready (a function of state only).
- Reset asserted mid-operation: IDLE next cycle, mask cleared.

Optional Feature:
- CHAINING_RECORD_WRITE_CHECK_EN.
  - Defined: adds output write_error (1 bit, sticky until the next alloc or reset). It sets on:
    - a matching-instIndex write whose bit is already set (duplicate);
    - a write outside the vd/vd+1 window;
    - a matching write while DONE.
  - Undefined: no port, no logic; these cases are silently ignored as above.

Decomposition:
- Shared package chaining_pkg:
  - OFFSET_W, REG_IDX_W, MASK_W, CNT_W.
  - Typedef chaining_record_t {vd_valid, vd, instIndex, elementMask}.
  - FSM enum record_state_e {IDLE, ACTIVE, DONE}.
- The read-side checker already consumes the same field layout through this package.
- One natural sub-module: chaining_mask_update. It does the one-hot decode of {vs[2:0],offset}, the new-bit detect, and the next-mask OR.

Test Plan:
- Allocate vd=5, inst=2, groupCount=3. Write (5,0),(5,1),(6,0) with inst=2 → mask bits 1280,1281,1536 set; record_done=1 the cycle after the third write.
- Write (5,0) twice, then (5,1), with groupCount=2 → counter 2 after the third write; DONE entered only then. With CHECK_EN, write_error=1 after the second write.
- Write with inst=3 into a record owning inst=2 → mask unchanged, counter 0.
- Finish inst=2 in the same cycle as write (5,7) → next cycle recordValid=0, mask all zero, alloc_ready=1.
- vd=7, write vs=8 offset 4 (window wrap, reg idx 0) → bit 4 set. Write vs=16 → ignored (write_error with CHECK_EN).
- Reset asserted while ACTIVE with 100 bits set → next cycle all outputs 0 and alloc_ready=1; a subsequent alloc starts with an empty mask.

Source files
------------

// File: rtl/chaining_pkg.sv
// -----------------------------------------------------------------------------
// chaining_pkg
// Shared definitions for the chaining record writer and the read-side hazard
// checkers that consume the same record layout.
//   OFFSET_W, REG_IDX_W : element-group offset / register-in-window index widths
//   MASK_W              : elementMask width, one bit per {reg[2:0], offset}
//   CNT_W               : written-group counter width (holds 0..MASK_W)
//   chaining_record_t   : the fields exported to the read-side checkers
//   record_state_e      : writer FSM states
//   inWindow()          : true when a written register falls in vd / vd+1
// -----------------------------------------------------------------------------
package chaining_pkg;

   localparam int OFFSET_W  = 8;
   localparam int REG_IDX_W = 3;
   localparam int SEL_W     = REG_IDX_W + OFFSET_W;
   localparam int MASK_W    = 1 << SEL_W;
   localparam int CNT_W     = $clog2(MASK_W) + 1;

   typedef struct packed {
      logic                vdValid;
      logic [4:0]          vd;
      logic [2:0]          instIndex;
      logic [MASK_W-1:0]   elementMask;
   } chaining_record_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } record_state_e;

   // The mask covers an 8-register window starting at vd's 8-aligned group,
   // plus the next group (wrapping mod 4) for widening writes into vd+1.
   function automatic logic inWindow(input logic [4:0] vs, input logic [4:0] vd);
      logic [1:0] upper;
      upper = vd[4:3] + 2'd1;
      return (vs[4:3] == vd[4:3]) || (vs[4:3] == upper);
   endfunction

endpackage

// File: rtl/chaining_mask_update.sv
// -----------------------------------------------------------------------------
// chaining_mask_update
// One-hot decode of {regIdx, offset}, detection of whether the addressed bit
// is newly set, and the OR that forms the next element mask.
//   mask     in  : current element mask
//   regIdx   in  : register index within the window (vs[2:0])
//   offset   in  : element-group offset
//   enable   in  : apply the update
//   nextMask out : mask with the addressed bit set when enabled
//   isNew    out : enabled and the addressed bit was previously clear
// -----------------------------------------------------------------------------
module chaining_mask_update
   import chaining_pkg::*;
(
   input  logic [MASK_W-1:0]    mask,
   input  logic [REG_IDX_W-1:0] regIdx,
   input  logic [OFFSET_W-1:0]  offset,
   input  logic                 enable,
   output logic [MASK_W-1:0]    nextMask,
   output logic                 isNew
);

   logic [SEL_W-1:0]  bitSel;
   logic [MASK_W-1:0] hit;

   assign bitSel = {regIdx, offset};

   genvar gi;
   generate
      for (gi = 0; gi < MASK_W; gi++) begin : gDecode
         assign hit[gi] = enable && (bitSel == SEL_W'(gi));
      end
   endgenerate

   assign nextMask = mask | hit;
   assign isNew    = enable && ((mask & hit) == '0);

endmodule

// File: rtl/chaining_record_writer.sv
// -----------------------------------------------------------------------------
// chaining_record_writer
// Writer-side owner of one chaining record: allocated at issue, marks element
// groups of vd/vd+1 as written back, released on retire or kill.
// Optional macro CHAINING_RECORD_WRITE_CHECK_EN adds the sticky write_error
// output (duplicate write, out-of-window write, or matching write while DONE).
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   alloc_*                         : allocation request / record free
//   write_*                         : completed VRF write (no backpressure)
//   finish_*                        : retire or kill of an instruction
//   record_bits_*                   : registered record fields
//   recordValid                     : record in ACTIVE or DONE
//   record_done                     : all groups written
//   write_error (optional)          : sticky protocol error flag
// -----------------------------------------------------------------------------
module chaining_record_writer
   import chaining_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic              alloc_vd_valid,
   input  logic [4:0]        alloc_vd,
   input  logic [2:0]        alloc_instIndex,
   input  logic [CNT_W-1:0]  alloc_groupCount,
   input  logic              write_valid,
   input  logic [4:0]        write_vs,
   input  logic [7:0]        write_offset,
   input  logic [2:0]        write_instIndex,
   input  logic              finish_valid,
   input  logic [2:0]        finish_instIndex,
   output logic              record_bits_vd_valid,
   output logic [4:0]        record_bits_vd_bits,
   output logic [2:0]        record_bits_instIndex,
   output logic [MASK_W-1:0] record_bits_elementMask,
   output logic              recordValid,
   output logic              record_done
`ifdef CHAINING_RECORD_WRITE_CHECK_EN
   ,
   output logic              write_error
`endif
);

   record_state_e    stateReg, stateNext;
   chaining_record_t recordReg;
   logic [CNT_W-1:0] cntReg, groupCountReg, cntNext;
   logic [MASK_W-1:0] maskNext;
   logic             bitIsNew;
   logic             instMatch, windowOk, writeHit, finishHit, allocTake, reachDone;

   assign instMatch = write_valid && (write_instIndex == recordReg.instIndex);
   assign windowOk  = inWindow(write_vs, recordReg.vd);
   assign writeHit  = (stateReg == ACTIVE) && instMatch && recordReg.vdValid && windowOk;
   assign finishHit = finish_valid && (finish_instIndex == recordReg.instIndex)
                      && (stateReg != IDLE);
   assign allocTake = (stateReg == IDLE) && alloc_valid;

   chaining_mask_update uMaskUpdate (
      .mask     (recordReg.elementMask),
      .regIdx   (write_vs[2:0]),
      .offset   (write_offset),
      .enable   (writeHit),
      .nextMask (maskNext),
      .isNew    (bitIsNew)
   );

   // Duplicate writes leave the count unchanged, so DONE needs distinct groups.
   assign cntNext   = cntReg + {{(CNT_W-1){1'b0}}, bitIsNew};
   assign reachDone = recordReg.vdValid && (cntNext == groupCountReg);

   // State register
   always_ff @(posedge clock) begin
      if (reset) stateReg <= IDLE;
      else       stateReg <= stateNext;
   end

   // Next-state logic; finish takes priority over completion.
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (alloc_valid) stateNext = ACTIVE;
         ACTIVE:  if (finishHit) stateNext = IDLE;
                  else if (reachDone) stateNext = DONE;
         DONE:    if (finishHit) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Output logic (state only, so alloc_ready has no input dependence)
   always_comb begin
      alloc_ready = (stateReg == IDLE);
      recordValid = (stateReg == ACTIVE) || (stateReg == DONE);
      record_done = (stateReg == DONE);
   end

   // Record fields, mask and counter
   always_ff @(posedge clock) begin
      if (reset) begin
         recordReg     <= '0;
         cntReg        <= '0;
         groupCountReg <= '0;
      end else if (allocTake) begin
         recordReg.vdValid     <= alloc_vd_valid;
         recordReg.vd          <= alloc_vd;
         recordReg.instIndex   <= alloc_instIndex;
         recordReg.elementMask <= '0;
         cntReg                <= '0;
         groupCountReg         <= alloc_groupCount;
      end else if (finishHit) begin
         recordReg.elementMask <= '0;
         cntReg                <= '0;
      end else if (writeHit) begin
         recordReg.elementMask <= maskNext;
         cntReg                <= cntNext;
      end
   end

   assign record_bits_vd_valid    = recordReg.vdValid;
   assign record_bits_vd_bits     = recordReg.vd;
   assign record_bits_instIndex   = recordReg.instIndex;
   assign record_bits_elementMask = recordReg.elementMask;

`ifdef CHAINING_RECORD_WRITE_CHECK_EN
   logic errorReg;
   always_ff @(posedge clock) begin
      if (reset || allocTake) begin
         errorReg <= 1'b0;
      end else if (instMatch && recordReg.vdValid &&
                   (((stateReg == ACTIVE) && (!windowOk || !bitIsNew)) ||
                    (stateReg == DONE))) begin
         errorReg <= 1'b1;
      end
   end
   assign write_error = errorReg;
`endif

endmodule

// File: tb/tb_chaining_record_writer.sv
module tb_chaining_record_writer;
   import chaining_pkg::*;

   logic              clock = 1'b0;
   logic              reset;
   logic              alloc_valid, alloc_ready, alloc_vd_valid;
   logic [4:0]        alloc_vd;
   logic [2:0]        alloc_instIndex;
   logic [CNT_W-1:0]  alloc_groupCount;
   logic              write_valid;
   logic [4:0]        write_vs;
   logic [7:0]        write_offset;
   logic [2:0]        write_instIndex;
   logic              finish_valid;
   logic [2:0]        finish_instIndex;
   logic              record_bits_vd_valid;
   logic [4:0]        record_bits_vd_bits;
   logic [2:0]        record_bits_instIndex;
   logic [MASK_W-1:0] record_bits_elementMask;
   logic              recordValid, record_done;
`ifdef CHAINING_RECORD_WRITE_CHECK_EN
   logic              write_error;
`endif

   int testsRun = 0;
   int testsFailed = 0;
   logic [MASK_W-1:0] expMask;

   chaining_record_writer dut (
      .clock                   (clock),
      .reset                   (reset),
      .alloc_valid             (alloc_valid),
      .alloc_ready             (alloc_ready),
      .alloc_vd_valid          (alloc_vd_valid),
      .alloc_vd                (alloc_vd),
      .alloc_instIndex         (alloc_instIndex),
      .alloc_groupCount        (alloc_groupCount),
      .write_valid             (write_valid),
      .write_vs                (write_vs),
      .write_offset            (write_offset),
      .write_instIndex         (write_instIndex),
      .finish_valid            (finish_valid),
      .finish_instIndex        (finish_instIndex),
      .record_bits_vd_valid    (record_bits_vd_valid),
      .record_bits_vd_bits     (record_bits_vd_bits),
      .record_bits_instIndex   (record_bits_instIndex),
      .record_bits_elementMask (record_bits_elementMask),
      .recordValid             (recordValid),
      .record_done             (record_done)
`ifdef CHAINING_RECORD_WRITE_CHECK_EN
      ,
      .write_error             (write_error)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: run time exceeded, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic doAlloc(input logic vv, input logic [4:0] vd, input logic [2:0] inst,
                          input int gc);
      alloc_valid = 1'b1; alloc_vd_valid = vv; alloc_vd = vd;
      alloc_instIndex = inst; alloc_groupCount = CNT_W'(gc);
      step();
      alloc_valid = 1'b0;
      $display("[TB] alloc vd=%0d inst=%0d gc=%0d", vd, inst, gc);
   endtask

   task automatic doWrite(input logic [4:0] vs, input logic [7:0] off, input logic [2:0] inst);
      write_valid = 1'b1; write_vs = vs; write_offset = off; write_instIndex = inst;
      step();
      write_valid = 1'b0;
   endtask

   task automatic doFinish(input logic [2:0] inst);
      finish_valid = 1'b1; finish_instIndex = inst;
      step();
      finish_valid = 1'b0;
      $display("[TB] finish inst=%0d", inst);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      testsRun++;
      if ({alloc_ready, recordValid, record_done} !== 3'b100) begin
         testsFailed++;
         $display("FAIL reset_flags: got %b required 100", {alloc_ready, recordValid, record_done});
      end
      testsRun++;
      if ({record_bits_vd_valid, record_bits_vd_bits, record_bits_instIndex} !== 9'd0
          || record_bits_elementMask !== '0) begin
         testsFailed++;
         $display("FAIL reset_fields: got vd=%0d inst=%0d ones=%0d required all zero",
                  record_bits_vd_bits, record_bits_instIndex, $countones(record_bits_elementMask));
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      doAlloc(1'b1, 5'd5, 3'd2, 3);
      testsRun++;
      if ({alloc_ready, recordValid, record_bits_vd_valid, record_bits_vd_bits,
           record_bits_instIndex} !== {1'b0, 1'b1, 1'b1, 5'd5, 3'd2}
          || record_bits_elementMask !== '0) begin
         testsFailed++;
         $display("FAIL basic_alloc: got ready=%b valid=%b vd=%0d inst=%0d required 0 1 5 2",
                  alloc_ready, recordValid, record_bits_vd_bits, record_bits_instIndex);
      end
      doWrite(5'd5, 8'd0, 3'd2);
      testsRun++;
      if (record_bits_elementMask[1280] !== 1'b1 || record_done !== 1'b0) begin
         testsFailed++;
         $display("FAIL basic_first_write: got bit1280=%b done=%b required 1 0",
                  record_bits_elementMask[1280], record_done);
      end
      doWrite(5'd5, 8'd1, 3'd2);
      testsRun++;
      if (record_done !== 1'b0) begin
         testsFailed++;
         $display("FAIL basic_not_done: got done=%b required 0", record_done);
      end
      doWrite(5'd6, 8'd0, 3'd2);
      expMask = '0; expMask[1280] = 1'b1; expMask[1281] = 1'b1; expMask[1536] = 1'b1;
      testsRun++;
      if (record_bits_elementMask !== expMask || record_done !== 1'b1 || recordValid !== 1'b1) begin
         testsFailed++;
         $display("FAIL basic_done: got ones=%0d done=%b valid=%b required mask{1280,1281,1536} 1 1",
                  $countones(record_bits_elementMask), record_done, recordValid);
      end
      doFinish(3'd2);
      testsRun++;
      if ({alloc_ready, recordValid, record_done} !== 3'b100 || record_bits_elementMask !== '0) begin
         testsFailed++;
         $display("FAIL basic_finish: got flags=%b ones=%0d required 100 0",
                  {alloc_ready, recordValid, record_done}, $countones(record_bits_elementMask));
      end
   endtask

   task automatic test_duplicate();
      doAlloc(1'b1, 5'd5, 3'd2, 2);
      doWrite(5'd5, 8'd0, 3'd2);
      doWrite(5'd5, 8'd0, 3'd2);
      testsRun++;
      if (record_done !== 1'b0) begin
         testsFailed++;
         $display("FAIL dup_no_done: got done=%b required 0", record_done);
      end
`ifdef CHAINING_RECORD_WRITE_CHECK_EN
      testsRun++;
      if (write_error !== 1'b1) begin
         testsFailed++;
         $display("FAIL dup_error: got write_error=%b required 1", write_error);
      end
`endif
      doWrite(5'd5, 8'd1, 3'd2);
      testsRun++;
      if (record_done !== 1'b1) begin
         testsFailed++;
         $display("FAIL dup_done: got done=%b required 1", record_done);
      end
      doWrite(5'd5, 8'd2, 3'd2);
      testsRun++;
      if (record_bits_elementMask[1282] !== 1'b0 || $countones(record_bits_elementMask) != 2) begin
         testsFailed++;
         $display("FAIL done_frozen: got bit1282=%b ones=%0d required 0 2",
                  record_bits_elementMask[1282], $countones(record_bits_elementMask));
      end
      doFinish(3'd2);
   endtask

   task automatic test_mismatch();
      doAlloc(1'b1, 5'd5, 3'd2, 1);
`ifdef CHAINING_RECORD_WRITE_CHECK_EN
      testsRun++;
      if (write_error !== 1'b0) begin
         testsFailed++;
         $display("FAIL alloc_clears_error: got write_error=%b required 0", write_error);
      end
`endif
      doWrite(5'd5, 8'd0, 3'd3);
      testsRun++;
      if (record_bits_elementMask !== '0 || record_done !== 1'b0) begin
         testsFailed++;
         $display("FAIL mismatch_ignored: got ones=%0d done=%b required 0 0",
                  $countones(record_bits_elementMask), record_done);
      end
      doWrite(5'd5, 8'd0, 3'd2);
      testsRun++;
      if (record_done !== 1'b1) begin
         testsFailed++;
         $display("FAIL mismatch_then_match: got done=%b required 1", record_done);
      end
      doFinish(3'd3);
      testsRun++;
      if (recordValid !== 1'b1) begin
         testsFailed++;
         $display("FAIL wrong_finish: got recordValid=%b required 1", recordValid);
      end
      doFinish(3'd2);
   endtask

   task automatic test_finish_write();
      doAlloc(1'b1, 5'd5, 3'd2, 4);
      doWrite(5'd5, 8'd0, 3'd2);
      write_valid = 1'b1; write_vs = 5'd5; write_offset = 8'd7; write_instIndex = 3'd2;
      finish_valid = 1'b1; finish_instIndex = 3'd2;
      step();
      write_valid = 1'b0; finish_valid = 1'b0;
      testsRun++;
      if ({alloc_ready, recordValid, record_done} !== 3'b100 || record_bits_elementMask !== '0) begin
         testsFailed++;
         $display("FAIL finish_beats_write: got flags=%b ones=%0d required 100 0",
                  {alloc_ready, recordValid, record_done}, $countones(record_bits_elementMask));
      end
   endtask

   task automatic test_alloc_finish_idle();
      finish_valid = 1'b1; finish_instIndex = 3'd1;
      doAlloc(1'b1, 5'd2, 3'd1, 5);
      finish_valid = 1'b0;
      testsRun++;
      if (recordValid !== 1'b1 || record_bits_instIndex !== 3'd1) begin
         testsFailed++;
         $display("FAIL alloc_with_finish: got valid=%b inst=%0d required 1 1",
                  recordValid, record_bits_instIndex);
      end
      doFinish(3'd1);
   endtask

   task automatic test_window();
      doAlloc(1'b1, 5'd7, 3'd4, 8);
      doWrite(5'd8, 8'd4, 3'd4);
      doWrite(5'd16, 8'd9, 3'd4);
      expMask = '0; expMask[4] = 1'b1;
      testsRun++;
      if (record_bits_elementMask !== expMask) begin
         testsFailed++;
         $display("FAIL window_wrap: got ones=%0d bit4=%b bit9=%b required only bit4",
                  $countones(record_bits_elementMask), record_bits_elementMask[4],
                  record_bits_elementMask[9]);
      end
`ifdef CHAINING_RECORD_WRITE_CHECK_EN
      testsRun++;
      if (write_error !== 1'b1) begin
         testsFailed++;
         $display("FAIL window_error: got write_error=%b required 1", write_error);
      end
`endif
      doWrite(5'd7, 8'd3, 3'd4);
      expMask[7*256+3] = 1'b1;
      testsRun++;
      if (record_bits_elementMask !== expMask) begin
         testsFailed++;
         $display("FAIL window_same: got ones=%0d bit1795=%b required 2 1",
                  $countones(record_bits_elementMask), record_bits_elementMask[1795]);
      end
      doFinish(3'd4);
   endtask

   task automatic test_novd();
      doAlloc(1'b0, 5'd3, 3'd6, 1);
      doWrite(5'd3, 8'd0, 3'd6);
      testsRun++;
      if (record_bits_elementMask !== '0 || record_done !== 1'b0 || recordValid !== 1'b1) begin
         testsFailed++;
         $display("FAIL novd_hold: got ones=%0d done=%b valid=%b required 0 0 1",
                  $countones(record_bits_elementMask), record_done, recordValid);
      end
      doFinish(3'd6);
      testsRun++;
      if (alloc_ready !== 1'b1) begin
         testsFailed++;
         $display("FAIL novd_finish: got alloc_ready=%b required 1", alloc_ready);
      end
   endtask

   task automatic test_reset_mid();
      doAlloc(1'b1, 5'd0, 3'd1, 200);
      expMask = '0;
      for (int i = 0; i < 100; i++) begin
         doWrite(5'd0, 8'(i), 3'd1);
         expMask[i] = 1'b1;
      end
      testsRun++;
      if (record_bits_elementMask !== expMask || record_done !== 1'b0) begin
         testsFailed++;
         $display("FAIL mid_mask: got ones=%0d done=%b required 100 0",
                  $countones(record_bits_elementMask), record_done);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      testsRun++;
      if ({alloc_ready, recordValid, record_done, record_bits_vd_valid} !== 4'b1000
          || record_bits_elementMask !== '0 || record_bits_instIndex !== 3'd0) begin
         testsFailed++;
         $display("FAIL mid_reset: got flags=%b ones=%0d inst=%0d required 1000 0 0",
                  {alloc_ready, recordValid, record_done, record_bits_vd_valid},
                  $countones(record_bits_elementMask), record_bits_instIndex);
      end
      doAlloc(1'b1, 5'd0, 3'd1, 4);
      testsRun++;
      if (record_bits_elementMask !== '0 || recordValid !== 1'b1) begin
         testsFailed++;
         $display("FAIL realloc_empty: got ones=%0d valid=%b required 0 1",
                  $countones(record_bits_elementMask), recordValid);
      end
      doFinish(3'd1);
   endtask

   initial begin
      reset = 1'b1;
      alloc_valid = 1'b0; alloc_vd_valid = 1'b0; alloc_vd = '0;
      alloc_instIndex = '0; alloc_groupCount = '0;
      write_valid = 1'b0; write_vs = '0; write_offset = '0; write_instIndex = '0;
      finish_valid = 1'b0; finish_instIndex = '0;
      expMask = '0;
      test_reset();
      test_basic();
      test_duplicate();
      test_mismatch();
      test_finish_write();
      test_alloc_finish_idle();
      test_window();
      test_novd();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
